// File: rtl/dsm_pkg.sv
// dsm_pkg: constants and width helper shared by the DSM modulator and CIC decimator
package dsm_pkg;
  localparam int CIC_ORDER = 3;
  function automatic int acc_w(input int osr_log2);
    return CIC_ORDER * osr_log2 + 1;
  endfunction
endpackage

// File: rtl/cic_integrator_stage.sv
// cic_integrator_stage: one modulo-2**W CIC integrator that accumulates only on enable
module cic_integrator_stage #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  logic [W-1:0] acc_q;
  always_ff @(posedge clk)
    if (rst) acc_q <= '0;
    else if (en) acc_q <= acc_q + din;
  assign acc = acc_q;
endmodule

// File: rtl/dsm_cic_decimator.sv
// dsm_cic_decimator: sinc3 decimator turning a strobed 1-bit DSM stream into unsigned PCM
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int OSR_LOG2 = 8,
  parameter int OUT_W    = 8
) (
  input  logic                clk50m,
  input  logic                rst,
  input  logic                en,
  input  logic                bit_in,
  output logic [OUT_W-1:0]    dout,
  output logic                dout_valid,
  output logic [OSR_LOG2-1:0] frame_cnt
);
  localparam int ACC_W = acc_w(OSR_LOG2);
  localparam int SHIFT = CIC_ORDER * OSR_LOG2 - OUT_W;
  logic [ACC_W-1:0] i1, i2, i3;
  logic [ACC_W-1:0] c1, c2, c3, scaled;
  logic [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [OSR_LOG2-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] warm_q, warm_d;
  logic dec_pend_q, dec_pend_d, warm_done;
  logic [OUT_W-1:0] dout_q, dout_d, sat;
  logic dout_valid_q, dout_valid_d;
  cic_integrator_stage #(.W(ACC_W)) u_i1 (
    .clk(clk50m), .rst(rst), .en(en), .din({{(ACC_W-1){1'b0}}, bit_in}), .acc(i1)
  );
  cic_integrator_stage #(.W(ACC_W)) u_i2 (
    .clk(clk50m), .rst(rst), .en(en), .din(i1), .acc(i2)
  );
  cic_integrator_stage #(.W(ACC_W)) u_i3 (
    .clk(clk50m), .rst(rst), .en(en), .din(i2), .acc(i3)
  );
  // i3 is read as a register here, so an en in the dec_pend cycle cannot disturb the snapshot
  always_comb begin
    c1           = i3 - d1_q;
    c2           = c1 - d2_q;
    c3           = c2 - d3_q;
    scaled       = c3 >> SHIFT;
    sat          = |scaled[ACC_W-1:OUT_W] ? '1 : scaled[OUT_W-1:0];
    warm_done    = warm_q == 2'd3;
    frame_cnt_d  = en ? frame_cnt_q + OSR_LOG2'(1) : frame_cnt_q;
    dec_pend_d   = en && (&frame_cnt_q);
    warm_d       = dec_pend_q && !warm_done ? warm_q + 2'd1 : warm_q;
    d1_d         = dec_pend_q ? i3 : d1_q;
    d2_d         = dec_pend_q ? c1 : d2_q;
    d3_d         = dec_pend_q ? c2 : d3_q;
    dout_valid_d = dec_pend_q && warm_done;
    dout_d       = dout_valid_d ? sat : dout_q;
  end
  always_ff @(posedge clk50m)
    if (rst) begin
      frame_cnt_q  <= '0;
      dec_pend_q   <= 1'b0;
      warm_q       <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      dec_pend_q   <= dec_pend_d;
      warm_q       <= warm_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      d3_q         <= d3_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_dsm_cic_decimator.sv
// tb_dsm_cic_decimator: directed/random streams checked against a sinc3 FIR reference model
module tb_dsm_cic_decimator;
  localparam int LOG2 = 4;
  localparam int OSR  = 1 << LOG2;
  localparam int OW   = 8;
  localparam int HL   = 3 * OSR - 2;
  localparam int SH   = 3 * LOG2 - OW;
  logic clk50m = 1'b0;
  logic rst, en, bit_in;
  logic [OW-1:0] dout;
  logic dout_valid;
  logic [LOG2-1:0] frame_cnt;
  int checks = 0, errors = 0;
  int h[HL];
  int b2[2*OSR-1];
  bit xs[$];
  int expq[$];
  int frames, held, last_pulse, cyc;
  bit prev_valid, cont;

  dsm_cic_decimator #(.OSR_LOG2(LOG2), .OUT_W(OW)) dut (
    .clk50m(clk50m), .rst(rst), .en(en), .bit_in(bit_in),
    .dout(dout), .dout_valid(dout_valid), .frame_cnt(frame_cnt)
  );

  always #10 clk50m = ~clk50m;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // sinc3 = three cascaded length-OSR boxcars; the integrator cascade adds two samples of delay
  function automatic int model(input int n);
    int y = 0;
    for (int j = 0; j < HL; j++)
      if (n - 2 - j >= 0) y += h[j] * int'(xs[n-2-j]);
    y = y >> SH;
    return y > 255 ? 255 : y;
  endfunction

  task automatic tick(input logic e, input logic b);
    en = e;
    bit_in = b;
    @(posedge clk50m);
    #1;
    cyc++;
    if (e) begin
      xs.push_back(b);
      if (xs.size() % OSR == 0) begin
        frames++;
        if (frames >= 4) expq.push_back(model(xs.size() - 1));
      end
    end
    check("frame_cnt", int'(frame_cnt), xs.size() % OSR);
    if (dout_valid) begin
      check("double_pulse", int'(prev_valid), 0);
      check("unexpected_pulse", int'(expq.size() > 0), 1);
      if (expq.size() > 0) check("dout", int'(dout), expq.pop_front());
      if (cont && last_pulse >= 0) check("pulse_spacing", cyc - last_pulse, OSR);
      last_pulse = cyc;
      held = int'(dout);
    end else check("dout_hold", int'(dout), held);
    prev_valid = dout_valid;
  endtask

  task automatic strobe(input logic b, input int gap);
    tick(1'b1, b);
    repeat (gap) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    bit_in = 1'b0;
    @(posedge clk50m);
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    xs.delete();
    expq.delete();
    frames = 0;
    held = 0;
    prev_valid = 1'b0;
    last_pulse = -1;
  endtask

  task automatic drain();
    repeat (4) tick(1'b0, 1'b0);
    check("missing_pulse", expq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    bit_in = 1'b0;
    cyc = 0;
    cont = 1'b0;
    foreach (b2[i]) b2[i] = 0;
    foreach (h[i]) h[i] = 0;
    for (int a = 0; a < OSR; a++)
      for (int b = 0; b < OSR; b++) b2[a+b] += 1;
    for (int a = 0; a < 2 * OSR - 1; a++)
      for (int b = 0; b < OSR; b++) h[a+b] += b2[a];
    repeat (2) @(posedge clk50m);
    do_reset();
    for (int i = 0; i < 6 * OSR; i++) strobe(1'b1, 3);
    drain();
    do_reset();
    for (int i = 0; i < 6 * OSR; i++) strobe(1'b0, 3);
    drain();
    do_reset();
    for (int i = 0; i < 6 * OSR; i++) strobe(logic'(i % 2 == 0), 3);
    drain();
    do_reset();
    for (int i = 0; i < 6 * OSR; i++) strobe(logic'(i % 4 == 0), int'($urandom_range(0, 20)));
    drain();
    do_reset();
    for (int i = 0; i < 4 * OSR + 7; i++) strobe(1'b1, 3);
    check("pre_rst_frame_cnt", int'(frame_cnt), 7);
    do_reset();
    for (int i = 0; i < 4 * OSR; i++) strobe(1'b1, 3);
    drain();
    do_reset();
    cont = 1'b1;
    for (int i = 0; i < 6 * OSR; i++) strobe(1'b1, 0);
    drain();
    cont = 1'b0;
    do_reset();
    for (int i = 0; i < 8 * OSR; i++) strobe(logic'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
